// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared encodings for the multi-cycle RISC-V core
package rv_core_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [4:0] {
    S_FETCH      = 5'b00001,
    S_DECODE     = 5'b00010,
    S_EXECUTE    = 5'b00100,
    S_WRITE_BACK = 5'b01000,
    S_TRAP       = 5'b10000
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {K_ALU, K_BRANCH, K_JAL, K_JALR} kind_t;

  // alt selects SUB/SRA; callers only raise it when inst[30] is meaningful
  function automatic alu_op_t base_alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu.sv
// rtl/rv_alu.sv - combinational integer ALU with branch compare flags
module rv_alu
  import rv_core_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'd0, lt};
      ALU_SLTU:   y = {31'd0, ltu};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_core.sv
// rtl/rv_multicycle_core.sv - four-state RV32I/E integer core, traps on unsupported encodings
module rv_multicycle_core
  import rv_core_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_out
);

  localparam int         IW        = $clog2(NUM_REGS);
  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  state_t      state;
  logic [31:0] pc, inst, a_q, b_q, result_q, next_pc_q;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_b, imm_u, imm_j, rs1_val, rs2_val;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[IW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[IW-1:0]];

  // inst stays latched for the whole instruction, so decode is shared by all states
  kind_t       kind;
  alu_op_t     alu_op;
  logic [31:0] dec_a, dec_b;
  logic        use_rd, use_rs1, use_rs2, bad_enc, illegal;

  always_comb begin
    kind    = K_ALU;
    alu_op  = ALU_ADD;
    dec_a   = rs1_val;
    dec_b   = imm_i;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    bad_enc = 1'b0;
    case (opcode)
      OP_IMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        alu_op  = base_alu_op(f3, (f3 == F3_SR) && (f7 == F7_ALT));
        bad_enc = ((f3 == F3_SLL) && (f7 != F7_BASE)) ||
                  ((f3 == F3_SR) && (f7 != F7_BASE) && (f7 != F7_ALT));
      end
      OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_b   = rs2_val;
        alu_op  = base_alu_op(f3, f7 == F7_ALT);
        bad_enc = !((f7 == F7_BASE) ||
                    ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
      end
      LUI: begin
        use_rd = 1'b1;
        alu_op = ALU_PASS_B;
        dec_b  = imm_u;
      end
      AUIPC: begin
        use_rd = 1'b1;
        dec_a  = pc;
        dec_b  = imm_u;
      end
      JAL: begin
        use_rd = 1'b1;
        kind   = K_JAL;
      end
      JALR: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        kind    = K_JALR;
        bad_enc = (f3 != 3'd0);
      end
      BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        kind    = K_BRANCH;
        alu_op  = ALU_SUB;
        dec_b   = rs2_val;
        bad_enc = (f3 == 3'd2) || (f3 == 3'd3);
      end
      default: bad_enc = 1'b1;
    endcase
  end

  assign illegal = bad_enc ||
                   (use_rd  && ({1'b0, rd}  >= REG_LIMIT)) ||
                   (use_rs1 && ({1'b0, rs1} >= REG_LIMIT)) ||
                   (use_rs2 && ({1'b0, rs2} >= REG_LIMIT));

  logic [31:0] alu_y;
  logic        cmp_eq, cmp_lt, cmp_ltu;

  rv_alu u_alu (
    .op  (alu_op),
    .a   (a_q),
    .b   (b_q),
    .y   (alu_y),
    .eq  (cmp_eq),
    .lt  (cmp_lt),
    .ltu (cmp_ltu)
  );

  logic        branch_cond, taken;
  logic [31:0] target, link;

  assign link = pc + 32'd4;

  always_comb begin
    case (f3)
      F3_BEQ:  branch_cond = cmp_eq;
      F3_BNE:  branch_cond = !cmp_eq;
      F3_BLT:  branch_cond = cmp_lt;
      F3_BGE:  branch_cond = !cmp_lt;
      F3_BLTU: branch_cond = cmp_ltu;
      F3_BGEU: branch_cond = !cmp_ltu;
      default: branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = link;
    case (kind)
      K_BRANCH: begin
        taken = branch_cond;
        if (branch_cond) target = pc + imm_b;
      end
      K_JAL: begin
        taken  = 1'b1;
        target = pc + imm_j;
      end
      K_JALR: begin
        taken  = 1'b1;
        target = alu_y & ~32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      inst      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      next_pc_q <= '0;
      imem_req  <= 1'b1;
      retire    <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            inst     <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state  <= S_TRAP;
            halted <= 1'b1;
          end else begin
            a_q   <= dec_a;
            b_q   <= dec_b;
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (taken && (target[1:0] != 2'b00)) begin
            state  <= S_TRAP;
            halted <= 1'b1;
          end else begin
            result_q  <= ((kind == K_JAL) || (kind == K_JALR)) ? link : alu_y;
            next_pc_q <= target;
            retire    <= 1'b1;
            state     <= S_WRITE_BACK;
          end
        end
        S_WRITE_BACK: begin
          if ((kind != K_BRANCH) && (rd != 5'd0)) regs[rd[IW-1:0]] <= result_q;
          pc       <= next_pc_q;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_TRAP: ;
        default: begin
          state  <= S_TRAP;
          halted <= 1'b1;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb/tb_rv_multicycle_core.sv - scoreboard bench for rv_multicycle_core
module tb_rv_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b1;
  logic        imem_req, retire, halted;
  logic [31:0] imem_addr, imem_rdata, pc_out;
  logic        req32, retire32, halted32;
  logic [31:0] addr32, rdata32, pc32;
  logic [31:0] prog [64];
  int          cyc_cnt = 0;
  int          last_rc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    int          rd;
    logic [31:0] val;
    logic [31:0] npc;
    int          gap;
    int          stall;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign imem_rdata = (imem_addr < 32'd256) ? prog[imem_addr[7:2]] : 32'h0;
  assign rdata32    = (addr32 < 32'd256) ? prog[addr32[7:2]] : 32'h0;

  rv_multicycle_core #(.NUM_REGS(16), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (valid),
    .retire     (retire),
    .halted     (halted),
    .pc_out     (pc_out)
  );

  rv_multicycle_core #(.NUM_REGS(32), .RESET_PC(32'h0)) dut32 (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (req32),
    .imem_addr  (addr32),
    .imem_rdata (rdata32),
    .imem_valid (valid),
    .retire     (retire32),
    .halted     (halted32),
    .pc_out     (pc32)
  );

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] opc);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), opc};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] opc);
    return {imm20[19:0], 5'(rd), opc};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic push(input logic [31:0] pc, input int rd, input logic [31:0] val,
                      input logic [31:0] npc, input int gap, input int stall);
    exp_t e;
    e.pc = pc; e.rd = rd; e.val = val; e.npc = npc; e.gap = gap; e.stall = stall;
    sb.push_back(e);
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = 32'h0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_rst_req"}, 32'(imem_req), 32'd1);
    check({tag, "_rst_halted"}, 32'(halted), 32'd0);
    check({tag, "_rst_retire"}, 32'(retire), 32'd0);
    check({tag, "_rst_pc"}, pc_out, 32'h0);
    reset = 1'b1;
    last_rc = cyc_cnt;
    sb.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int   c = 0;
    int   waited = 0;
    bit   pend = 1'b0;
    exp_t e;
    while ((sb.size() != 0 || pend) && c < budget) begin
      @(negedge clk);
      c++;
      if (pend) begin
        if (e.rd != 0) check({tag, "_rd"}, dut.regs[e.rd], e.val);
        check({tag, "_npc"}, pc_out, e.npc);
        pend = 1'b0;
      end
      if (retire && sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_pc"}, pc_out, e.pc);
        if (e.gap != 0) check({tag, "_gap"}, 32'(cyc_cnt - last_rc), 32'(e.gap));
        last_rc = cyc_cnt;
        waited = 0;
        pend = 1'b1;
      end
      if (imem_req && sb.size() != 0 && waited < sb[0].stall) begin
        valid = 1'b0;
        waited++;
        check({tag, "_hold_addr"}, imem_addr, sb[0].pc);
      end else begin
        valid = 1'b1;
      end
    end
    check({tag, "_drained"}, 32'(sb.size()) + 32'(pend), 32'd0);
    sb.delete();
    valid = 1'b1;
  endtask

  task automatic expect_trap(input string tag, input logic [31:0] pc, input int budget);
    int c = 0;
    int rets = 0;
    while (!halted && c < budget) begin
      @(negedge clk);
      c++;
      if (retire) rets++;
    end
    @(negedge clk);
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_trap_pc"}, pc_out, pc);
    check({tag, "_no_retire"}, 32'(rets) + 32'(retire), 32'd0);
    check({tag, "_no_req"}, 32'(imem_req), 32'd0);
  endtask

  logic [31:0] bad_words [5];

  initial begin
    // ADDI chain, then the all-zero word traps
    clear_prog();
    prog[0] = enc_i(5, 0, 0, 1, 7'b0010011);
    prog[1] = enc_i(-7, 1, 0, 2, 7'b0010011);
    do_reset("addi");
    push(32'd0, 1, 32'd5, 32'd4, 0, 0);
    push(32'd4, 2, 32'hFFFF_FFFE, 32'd8, 4, 0);
    drain("addi", 30);
    expect_trap("zero_word", 32'd8, 10);

    // ALU, shifts, compares, AUIPC and signed/unsigned branches
    clear_prog();
    prog[0]  = enc_u(20'h80000, 1, 7'b0110111);
    prog[1]  = enc_i(12'h404, 1, 5, 3, 7'b0010011);
    prog[2]  = enc_i(4, 1, 5, 4, 7'b0010011);
    prog[3]  = enc_r(0, 0, 1, 2, 5);
    prog[4]  = enc_r(0, 0, 1, 3, 6);
    prog[5]  = enc_r(0, 1, 1, 0, 7);
    prog[6]  = enc_i(-1, 1, 4, 8, 7'b0010011);
    prog[7]  = enc_u(1, 10, 7'b0010111);
    prog[8]  = enc_b(8, 0, 1, 4);
    prog[10] = enc_b(8, 1, 0, 7);
    do_reset("alu");
    push(32'd0,  1,  32'h8000_0000, 32'd4,  0, 0);
    push(32'd4,  3,  32'hF800_0000, 32'd8,  4, 0);
    push(32'd8,  4,  32'h0800_0000, 32'd12, 4, 0);
    push(32'd12, 5,  32'd1,         32'd16, 4, 0);
    push(32'd16, 6,  32'd0,         32'd20, 4, 0);
    push(32'd20, 7,  32'd0,         32'd24, 4, 0);
    push(32'd24, 8,  32'h7FFF_FFFF, 32'd28, 4, 0);
    push(32'd28, 10, 32'h0000_101C, 32'd32, 4, 0);
    push(32'd32, 0,  32'd0,         32'd40, 4, 0);
    push(32'd40, 0,  32'd0,         32'd44, 4, 0);
    drain("alu", 80);
    expect_trap("alu_end", 32'd44, 10);

    // loop via BNE, forward BEQ, JAL link, misaligned JALR target
    clear_prog();
    prog[0] = enc_i(1, 3, 0, 3, 7'b0010011);
    prog[1] = enc_i(2, 0, 0, 2, 7'b0010011);
    prog[2] = enc_b(-8, 2, 3, 1);
    prog[3] = enc_b(4, 0, 0, 0);
    prog[4] = enc_j(12, 1);
    prog[7] = enc_i(3, 1, 0, 0, 7'b1100111);
    do_reset("ctrl");
    push(32'd0,  3, 32'd1,  32'd4,  0, 0);
    push(32'd4,  2, 32'd2,  32'd8,  4, 0);
    push(32'd8,  0, 32'd0,  32'd0,  4, 0);
    push(32'd0,  3, 32'd2,  32'd4,  4, 0);
    push(32'd4,  2, 32'd2,  32'd8,  4, 0);
    push(32'd8,  0, 32'd0,  32'd12, 4, 0);
    push(32'd12, 0, 32'd0,  32'd16, 4, 0);
    push(32'd16, 1, 32'd20, 32'd28, 4, 0);
    drain("ctrl", 80);
    expect_trap("jalr_misaligned", 32'd28, 10);

    // imem_valid held low for three FETCH cycles of the second instruction
    clear_prog();
    prog[0] = enc_i(1, 0, 0, 1, 7'b0010011);
    prog[1] = enc_i(1, 1, 0, 2, 7'b0010011);
    do_reset("hs");
    push(32'd0, 1, 32'd1, 32'd4, 0, 0);
    push(32'd4, 2, 32'd2, 32'd8, 7, 3);
    drain("hs", 40);

    // register index beyond NUM_REGS traps only on the 16-register core
    clear_prog();
    prog[0] = enc_i(1, 0, 0, 16, 7'b0010011);
    do_reset("x16");
    expect_trap("x16", 32'd0, 10);
    repeat (8) @(negedge clk);
    check("x16_wide_reg", dut32.regs[16], 32'd1);
    check("x16_wide_halted", 32'(halted32), 32'd1);
    check("x16_wide_pc", pc32, 32'd4);
    check("x16_wide_quiet", 32'(req32) + 32'(retire32), 32'd0);

    // table of other illegal encodings
    bad_words[0] = 32'h0000_0003;
    bad_words[1] = 32'h4000_1033;
    bad_words[2] = enc_b(8, 0, 0, 2);
    bad_words[3] = 32'h0000_0073;
    bad_words[4] = enc_r(0, 17, 2, 0, 1);
    for (int k = 0; k < 5; k++) begin
      clear_prog();
      prog[0] = bad_words[k];
      do_reset($sformatf("bad%0d", k));
      expect_trap($sformatf("bad%0d", k), 32'd0, 10);
    end

    // reset in EXECUTE discards the instruction and clears the register file
    clear_prog();
    prog[0] = enc_i(7, 0, 0, 2, 7'b0010011);
    prog[1] = enc_i(9, 0, 0, 1, 7'b0010011);
    do_reset("mid");
    push(32'd0, 2, 32'd7, 32'd4, 0, 0);
    drain("mid", 20);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_req", 32'(imem_req), 32'd1);
    check("mid_halted", 32'(halted), 32'd0);
    check("mid_retire", 32'(retire), 32'd0);
    check("mid_pc", pc_out, 32'd0);
    check("mid_x1", dut.regs[1], 32'd0);
    check("mid_x2", dut.regs[2], 32'd0);
    reset = 1'b1;
    last_rc = cyc_cnt;
    push(32'd0, 2, 32'd7, 32'd4, 0, 0);
    drain("mid_restart", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
